// File: rtl/mem_req_bridge.sv
// Single-word request bridge from the rowhammer sequencer to an Avalon-MM master port,
// with completion confirm, saturating transaction counters and a sticky timeout flag.
module mem_req_bridge #(
  parameter int ADDR_WIDTH     = 64,
  parameter int WORD_WIDTH     = 64,
  parameter int ADDR_SHIFT     = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_address,
  input  logic [WORD_WIDTH-1:0]   req_wdata,
  output logic                    confirm,
  output logic [WORD_WIDTH-1:0]   rdata,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   avm_address,
  output logic                    avm_read,
  output logic                    avm_write,
  output logic [WORD_WIDTH-1:0]   avm_writedata,
  output logic [WORD_WIDTH/8-1:0] avm_byteenable,
  input  logic                    avm_waitrequest,
  input  logic [WORD_WIDTH-1:0]   avm_readdata,
  input  logic                    avm_readdatavalid,
  output logic [31:0]             rd_count,
  output logic [31:0]             wr_count,
  output logic                    timeout_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

  state_t                  state, state_nxt;
  logic                    wr_l;
  logic [ADDR_WIDTH-1:0]   addr_l;
  logic [WORD_WIDTH-1:0]   wdata_l;
  logic [TW-1:0]           tcnt;
  logic                    accept;
  logic                    rd_done;
  logic                    expired;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign accept  = (state == ISSUE) && !avm_waitrequest;
  assign rd_done = (state == WAIT_RD) && avm_readdatavalid;
  // Completion on the final allowed cycle wins over the abort.
  assign expired = (tcnt == TLIM) &&
                   (((state == ISSUE) && avm_waitrequest) ||
                    ((state == WAIT_RD) && !avm_readdatavalid));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = ISSUE;
      ISSUE:   if (accept) state_nxt = wr_l ? RESP : WAIT_RD;
               else if (expired) state_nxt = RESP;
      WAIT_RD: if (rd_done || expired) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy           = (state != IDLE);
    confirm        = (state == RESP);
    avm_read       = 1'b0;
    avm_write      = 1'b0;
    avm_address    = '0;
    avm_writedata  = '0;
    avm_byteenable = '0;
    if (state == ISSUE) begin
      avm_read       = !wr_l;
      avm_write      = wr_l;
      avm_address    = addr_l << ADDR_SHIFT;
      avm_writedata  = wdata_l;
      avm_byteenable = '1;
    end
  end

  // Request capture: only consumed while in ISSUE, so no reset needed.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && req_valid) begin
      wr_l    <= req_write;
      addr_l  <= req_address;
      wdata_l <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt        <= '0;
      rdata       <= '0;
      rd_count    <= '0;
      wr_count    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == IDLE) tcnt <= '0;
      else if ((state == ISSUE) || (state == WAIT_RD)) tcnt <= tcnt + 1'b1;
      if (accept && wr_l) wr_count <= sat_inc(wr_count);
      if (rd_done) begin
        rdata    <= avm_readdata;
        rd_count <= sat_inc(rd_count);
      end
      if (expired) begin
        timeout_err <= 1'b1;
        if (!wr_l) rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_bridge.sv
// Directed bench for mem_req_bridge: table of single transactions plus hand-written
// timeout, reset, stray-readdatavalid and back-to-back sequences.
module tb_mem_req_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write;
  logic [63:0] req_address, req_wdata;
  logic        confirm, busy, avm_read, avm_write, timeout_err;
  logic [63:0] rdata, avm_address, avm_writedata, avm_readdata;
  logic [7:0]  avm_byteenable;
  logic        avm_waitrequest, avm_readdatavalid;
  logic [31:0] rd_count, wr_count;

  logic        auto_mode;
  logic        man_wait, man_rdv;
  logic [63:0] man_rdata;
  logic        auto_rdv;
  logic [63:0] auto_rdata;

  localparam logic [63:0] K = 64'hF0F0_1234_5678_0F0F;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_wr, exp_rd;
  logic [63:0] exp_rdata;
  logic        exp_terr;

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] data;
    int          stall;
    int          rdv_dly;
    logic [63:0] exp_avm_addr;
    int          exp_lat;
  } vec_t;

  vec_t tbl[5];

  always #5 clk = ~clk;

  assign avm_waitrequest   = auto_mode ? 1'b0 : man_wait;
  assign avm_readdatavalid = auto_mode ? auto_rdv : man_rdv;
  assign avm_readdata      = auto_mode ? auto_rdata : man_rdata;

  // Zero-wait slave returning data one cycle after each accepted read.
  always @(posedge clk) begin
    auto_rdv   <= auto_mode && avm_read && !avm_waitrequest;
    auto_rdata <= avm_address ^ K;
  end

  mem_req_bridge #(
    .ADDR_WIDTH(64), .WORD_WIDTH(64), .ADDR_SHIFT(3), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write),
    .req_address(req_address), .req_wdata(req_wdata),
    .confirm(confirm), .rdata(rdata), .busy(busy),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .rd_count(rd_count), .wr_count(wr_count), .timeout_err(timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_state(input string nm);
    check({nm, " rdata"}, rdata, exp_rdata);
    check({nm, " wr_count"}, 64'(wr_count), 64'(exp_wr));
    check({nm, " rd_count"}, 64'(rd_count), 64'(exp_rd));
    check({nm, " timeout_err"}, 64'(timeout_err), 64'(exp_terr));
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int acc, conf_cyc;
    acc = 1 + v.stall;
    req_valid = 1'b1; req_write = v.wr; req_address = v.addr;
    req_wdata = v.wr ? v.data : 64'h0;
    man_wait = 1'b0; man_rdv = 1'b0;
    tick();
    req_valid = 1'b0;
    conf_cyc = -1;
    for (int c = 1; c <= 40 && conf_cyc < 0; c++) begin
      man_wait  = (c < acc);
      man_rdv   = !v.wr && (c == acc + v.rdv_dly);
      man_rdata = man_rdv ? v.data : 64'h0;
      if (c <= acc) begin
        check({nm, " cmd"}, 64'({avm_read, avm_write}), v.wr ? 64'd1 : 64'd2);
        check({nm, " avm_address"}, avm_address, v.exp_avm_addr);
        check({nm, " byteenable"}, 64'(avm_byteenable), 64'hFF);
        if (v.wr) check({nm, " writedata"}, avm_writedata, v.data);
      end
      if (confirm) conf_cyc = c;
      else tick();
    end
    man_rdv = 1'b0; man_wait = 1'b0;
    check({nm, " confirm cycle"}, 64'(conf_cyc), 64'(v.exp_lat));
    if (v.wr) exp_wr++;
    else begin
      exp_rd++;
      exp_rdata = v.data;
    end
    check_state(nm);
    tick();
    check({nm, " idle after"}, 64'({busy, confirm}), 64'd0);
  endtask

  task automatic run_timeout(input logic wr, input logic [63:0] addr, input string nm);
    int conf_cyc;
    req_valid = 1'b1; req_write = wr; req_address = addr; req_wdata = 64'h5555_AAAA_5555_AAAA;
    man_wait = wr; man_rdv = 1'b0;
    tick();
    req_valid = 1'b0;
    conf_cyc = -1;
    for (int c = 1; c <= 40 && conf_cyc < 0; c++) begin
      if (c == 1) check({nm, " cmd start"}, 64'({avm_read, avm_write}), wr ? 64'd1 : 64'd2);
      if (c == 16) check({nm, " cmd last"}, 64'({avm_read, avm_write}), wr ? 64'd1 : 64'd0);
      if (confirm) conf_cyc = c;
      else tick();
    end
    check({nm, " confirm cycle"}, 64'(conf_cyc), 64'd17);
    check({nm, " cmd dropped"}, 64'({avm_read, avm_write}), 64'd0);
    exp_terr = 1'b1;
    if (!wr) exp_rdata = 64'h0;
    check_state(nm);
    man_wait = 1'b0;
    tick();
    check({nm, " idle after"}, 64'({busy, confirm}), 64'd0);
  endtask

  initial begin
    int n_conf, n_acc, bad_seq, extra_conf;
    bit done;

    tbl[0] = '{1'b1, 64'h10, 64'hA5A5_A5A5_A5A5_A5A5, 0, 0, 64'h80, 2};
    tbl[1] = '{1'b0, 64'h20, 64'h0123_4567_89AB_CDEF, 3, 2, 64'h100, 7};
    tbl[2] = '{1'b0, 64'h1, 64'hDEAD_BEEF_CAFE_F00D, 0, 1, 64'h8, 3};
    tbl[3] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1122_3344_5566_7788, 2, 0,
               64'hFFFF_FFFF_FFFF_FFF8, 4};
    tbl[4] = '{1'b0, 64'h2000_0000_0000_0003, 64'h8000_0000_0000_0001, 1, 3, 64'h18, 6};

    auto_mode = 1'b0; man_wait = 1'b0; man_rdv = 1'b0; man_rdata = 64'h0;
    req_valid = 1'b0; req_write = 1'b0; req_address = 64'h0; req_wdata = 64'h0;
    exp_wr = 0; exp_rd = 0; exp_rdata = 64'h0; exp_terr = 1'b0;
    reset = 1'b1;
    tick(); tick(); tick();
    check("reset busy/confirm", 64'({busy, confirm}), 64'd0);
    check("reset cmd", 64'({avm_read, avm_write}), 64'd0);
    check("reset avm_address", avm_address, 64'h0);
    check("reset byteenable", 64'(avm_byteenable), 64'h0);
    check_state("reset");
    reset = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Stray readdatavalid while idle must be ignored.
    man_rdv = 1'b1; man_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    man_rdv = 1'b0;
    check("stray rdv confirm", 64'({busy, confirm}), 64'd0);
    check_state("stray rdv");

    run_timeout(1'b1, 64'h30, "wr timeout");
    run_timeout(1'b0, 64'h40, "rd timeout");
    run_vec(tbl[2], "read after timeout");

    // Reset while waiting for read data; late data must be dropped.
    req_valid = 1'b1; req_write = 1'b0; req_address = 64'h50; man_wait = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    check("pre-reset busy", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_wr = 0; exp_rd = 0; exp_rdata = 64'h0; exp_terr = 1'b0;
    check("mid-read reset busy/confirm", 64'({busy, confirm}), 64'd0);
    check("mid-read reset cmd", 64'({avm_read, avm_write}), 64'd0);
    check_state("mid-read reset");
    man_rdv = 1'b1; man_rdata = 64'h1234_5678_9ABC_DEF0;
    tick();
    man_rdv = 1'b0;
    check("late rdv confirm", 64'({busy, confirm}), 64'd0);
    check_state("late rdv");

    // Back-to-back: 1024 writes then 1024 reads with req_valid held high.
    auto_mode = 1'b1;
    n_conf = 0; n_acc = 0; bad_seq = 0; done = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_address = 64'h0; req_wdata = 64'h0;
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      if ((avm_read || avm_write) && !avm_waitrequest) begin
        if (avm_address !== (64'(n_acc) << 3) || avm_write !== (n_acc < 1024)) bad_seq++;
        n_acc++;
      end
      if (confirm) begin
        n_conf++;
        req_address = 64'(n_conf);
        req_wdata   = ~64'(n_conf);
        req_write   = (n_conf < 1024);
        if (n_conf == 2048) begin
          req_valid = 1'b0;
          done = 1'b1;
        end
      end
      tick();
    end
    extra_conf = 0;
    for (int c = 0; c < 6; c++) begin
      if (confirm) extra_conf++;
      tick();
    end
    check("b2b confirms", 64'(n_conf), 64'd2048);
    check("b2b accepts", 64'(n_acc), 64'd2048);
    check("b2b sequence errors", 64'(bad_seq), 64'd0);
    check("b2b extra confirms", 64'(extra_conf), 64'd0);
    check("b2b wr_count", 64'(wr_count), 64'd1024);
    check("b2b rd_count", 64'(rd_count), 64'd1024);
    check("b2b last rdata", rdata, 64'h3FF8 ^ K);
    check("b2b timeout_err", 64'(timeout_err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
